// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg: shared FSM state type, mode codes and default width for the serial arithmetic blocks.
// Rev 1.0
`default_nettype none

package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic MODE_SUB = 1'b0;
  localparam logic MODE_ADD = 1'b1;

  localparam int DEFAULT_WIDTH = 8;

endpackage

`default_nettype wire

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/busy/done handshake plus operand and result bus. Rev 1.0
// With SERIAL_SUB_ADD_MODE_EN the controller also drives a mode bit.
`default_nettype none

interface serial_subtractor_if
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SERIAL_SUB_ADD_MODE_EN
  logic             mode;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

`ifdef SERIAL_SUB_ADD_MODE_EN
  modport master (output start, a, b, mode, input busy, done, diff, borrow_out);
  modport slave  (input start, a, b, mode, output busy, done, diff, borrow_out);
`else
  modport master (output start, a, b, input busy, done, diff, borrow_out);
  modport slave  (input start, a, b, output busy, done, diff, borrow_out);
`endif

endinterface

`default_nettype wire

// File: rtl/serial_bit_cell.sv
// serial_bit_cell: one-bit full subtractor, or full adder when mode is MODE_ADD. Rev 1.0
`default_nettype none

module serial_bit_cell
  import serial_arith_pkg::*;
(
  input  logic a_bit_i,
  input  logic b_bit_i,
  input  logic bin_i,
  input  logic mode_i,
  output logic d_o,
  output logic bout_o
);

  logic axb;

  assign axb = a_bit_i ^ b_bit_i;
  assign d_o = axb ^ bin_i;

  always_comb begin
    bout_o = 1'b0;
    if (mode_i == MODE_ADD) begin
      bout_o = (a_bit_i & b_bit_i) | (bin_i & axb);
    end else begin
      bout_o = (~a_bit_i & b_bit_i) | (~axb & bin_i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial LSB-first a - b over WIDTH cycles, start/busy/done handshake. Rev 1.0
// Optional SERIAL_SUB_ADD_MODE_EN: latched mode bit selects addition (borrow_out carries the carry-out).
`default_nettype none

module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               bor_q, bor_d;
  logic               borrow_q, borrow_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               cell_mode;
  logic               cell_d;
  logic               cell_bout;
  logic [WIDTH-1:0]   res_next;

`ifdef SERIAL_SUB_ADD_MODE_EN
  logic mode_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_SUB;
    end else if (state_q == IDLE && bus.start) begin
      mode_q <= bus.mode;
    end
  end

  assign cell_mode = mode_q;
`else
  assign cell_mode = MODE_SUB;
`endif

  serial_bit_cell u_cell (
    .a_bit_i (a_q[0]),
    .b_bit_i (b_q[0]),
    .bin_i   (bor_q),
    .mode_i  (cell_mode),
    .d_o     (cell_d),
    .bout_o  (cell_bout)
  );

  // Result fills from the MSB so after WIDTH shifts bit 0 sits at position 0.
  assign res_next = {cell_d, res_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    diff_d   = diff_q;
    bor_d    = bor_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          res_d   = '0;
          bor_d   = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = res_next;
        bor_d = cell_bout;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          diff_d   = res_next;
          borrow_d = cell_bout;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      bor_q    <= 1'b0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      bor_q    <= bor_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.busy       = (state_q == SHIFT);
  assign bus.done       = (state_q == DONE);
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard bench for serial_subtractor (WIDTH=8). Rev 1.0
`default_nettype none

module tb_serial_subtractor;

  localparam int W = 8;
`ifdef SERIAL_SUB_ADD_MODE_EN
  localparam bit MODE_EN = 1'b1;
`else
  localparam bit MODE_EN = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bo;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   n_ops    = 0;
  int   done_cnt = 0;
  exp_t sb[$];
  exp_t held;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic add);
    logic [W:0] r;
    exp_t e;
    if (add) r = {1'b0, a} + {1'b0, b};
    else     r = {1'b0, a} - {1'b0, b};
    e.diff = r[W-1:0];
    e.bo   = r[W];
    return e;
  endfunction

  task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b, input logic md);
    sb.push_back(model(a, b, md & MODE_EN));
    n_ops++;
  endtask

  // Scoreboard consumer: pops on done, otherwise results must hold.
  initial begin
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = '0;
      end else if (bus.done) begin
        done_cnt++;
        check_eq("sb_nonempty_on_done", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          held = sb.pop_front();
          check_eq("diff", 32'(bus.diff), 32'(held.diff));
          check_eq("borrow_out", 32'(bus.borrow_out), 32'(held.bo));
        end
      end else begin
        check_eq("diff_hold", 32'(bus.diff), 32'(held.diff));
        check_eq("borrow_hold", 32'(bus.borrow_out), 32'(held.bo));
      end
    end
  end

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic md, input bit inject);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = ta;
    bus.b     = tbv;
`ifdef SERIAL_SUB_ADD_MODE_EN
    bus.mode  = md;
`endif
    push_exp(ta, tbv, md);
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < W; i++) begin
      check_eq("busy_shift", 32'(bus.busy), 32'd1);
      check_eq("done_low_shift", 32'(bus.done), 32'd0);
      if (inject && i == 3) begin
        bus.start = 1'b1;
        bus.a     = 8'h01;
        bus.b     = 8'h02;
      end else if (inject && i == 4) begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    check_eq("done_pulse", 32'(bus.done), 32'd1);
    check_eq("busy_in_done", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check_eq("done_one_cycle", 32'(bus.done), 32'd0);
    check_eq("busy_idle", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    int prev;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
`ifdef SERIAL_SUB_ADD_MODE_EN
    bus.mode  = 1'b0;
`endif
    #3;
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_done", 32'(bus.done), 32'd0);
    check_eq("rst_diff", 32'(bus.diff), 32'd0);
    check_eq("rst_borrow", 32'(bus.borrow_out), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(8'h0A, 8'h03, 1'b0, 1'b0);
    run_op(8'h03, 8'h0A, 1'b0, 1'b0);
    run_op(8'h00, 8'h01, 1'b0, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    end

    // Start and new operands during SHIFT must be ignored.
    run_op(8'h50, 8'h20, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    check_eq("no_extra_done", 32'(bus.done), 32'd0);

    // Start held high: back-to-back operations every WIDTH+2 cycles.
    @(negedge clk);
    bus.a     = 8'h10;
    bus.b     = 8'h01;
    bus.start = 1'b1;
    for (int k = 0; k < 3; k++) push_exp(8'h10, 8'h01, 1'b0);
    prev = 0;
    for (int n = 0; n < 3; n++) begin
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!bus.done && w < 30);
      check_eq("held_done_seen", 32'(bus.done), 32'd1);
      if (n > 0) check_eq("held_interval", 32'(cyc - prev), 32'd10);
      prev = cyc;
    end
    bus.start = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the 4th SHIFT cycle clears outputs before any clock edge.
    @(negedge clk);
    bus.a     = 8'h12;
    bus.b     = 8'h34;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", 32'(bus.busy), 32'd0);
    check_eq("midrst_done", 32'(bus.done), 32'd0);
    check_eq("midrst_diff", 32'(bus.diff), 32'd0);
    check_eq("midrst_borrow", 32'(bus.borrow_out), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h80, 8'h7F, 1'b0, 1'b0);

`ifdef SERIAL_SUB_ADD_MODE_EN
    run_op(8'hFF, 8'h01, 1'b1, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0);
    run_op(8'h7F, 8'h80, 1'b1, 1'b0);
`endif

    repeat (4) @(negedge clk);
    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    check_eq("done_count", 32'(done_cnt), 32'(n_ops));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
